// File: rtl/pipe_ex_stage_if.sv
// ---------------------------------------------------------------------------
// pipe_ex_stage_if
// Bundles the decode-side instruction fields, the MEM/WB forwarding taps and
// the EX-stage results into one bus between the pipeline and pipe_ex_stage.
// master : the surrounding pipeline (drives decode/forwarding, reads results)
// slave  : the execute stage itself
// ---------------------------------------------------------------------------
interface pipe_ex_stage_if #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
);
  // Pipeline control
  logic             flush;

  // Decode-stage instruction fields
  logic             id_valid;
  logic             id_wreg;
  logic             id_m2reg;
  logic             id_wmem;
  logic [3:0]       id_aluc;
  logic             id_shift;
  logic             id_aluimm;
  logic [RADDR-1:0] id_rs;
  logic [RADDR-1:0] id_rt;
  logic [RADDR-1:0] id_wn;
  logic [XLEN-1:0]  id_qa;
  logic [XLEN-1:0]  id_qb;
  logic [XLEN-1:0]  id_imm;

  // Forwarding taps from later stages
  logic             mem_wreg;
  logic [RADDR-1:0] mem_wn;
  logic [XLEN-1:0]  mem_res;
  logic             wb_wreg;
  logic [RADDR-1:0] wb_wn;
  logic [XLEN-1:0]  wb_res;

  // Execute-stage results
  logic             ex_busy;
  logic             ex_valid;
  logic             ex_wreg;
  logic             ex_m2reg;
  logic             ex_wmem;
  logic [RADDR-1:0] ex_wn;
  logic [XLEN-1:0]  ex_alu_result;
  logic [XLEN-1:0]  ex_di;
  logic             ex_z;

  modport master (
    output flush,
    output id_valid, id_wreg, id_m2reg, id_wmem, id_aluc, id_shift, id_aluimm,
    output id_rs, id_rt, id_wn, id_qa, id_qb, id_imm,
    output mem_wreg, mem_wn, mem_res, wb_wreg, wb_wn, wb_res,
    input  ex_busy, ex_valid, ex_wreg, ex_m2reg, ex_wmem, ex_wn,
    input  ex_alu_result, ex_di, ex_z
  );

  modport slave (
    input  flush,
    input  id_valid, id_wreg, id_m2reg, id_wmem, id_aluc, id_shift, id_aluimm,
    input  id_rs, id_rt, id_wn, id_qa, id_qb, id_imm,
    input  mem_wreg, mem_wn, mem_res, wb_wreg, wb_wn, wb_res,
    output ex_busy, ex_valid, ex_wreg, ex_m2reg, ex_wmem, ex_wn,
    output ex_alu_result, ex_di, ex_z
  );
endinterface

// File: rtl/pipe_ex_stage.sv
// ---------------------------------------------------------------------------
// pipe_ex_stage
// Execute stage with integrated ID/EX register, valid/flush handling and
// operand forwarding from MEM and WB (MEM wins, r0 never forwarded).
//
// Optional feature macro: PIPE_EX_MUL_EN
//   defined   : aluc 1011 runs a radix-2 shift-add multiplier that holds the
//               stage (ex_busy) for XLEN+1 cycles, result in the XLEN+2th.
//   undefined : aluc 1011 completes in one cycle with result 0, ex_busy = 0.
// ---------------------------------------------------------------------------
module pipe_ex_stage #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic            clk,
  input  logic            clrn,
  pipe_ex_stage_if.slave  bus
);

  localparam int         SHW    = $clog2(XLEN);
  localparam logic [3:0] OP_MUL = 4'b1011;

  // ID/EX register contents
  logic             valid_q;
  logic             wreg_q;
  logic             m2reg_q;
  logic             wmem_q;
  logic [3:0]       aluc_q;
  logic             shift_q;
  logic             aluimm_q;
  logic [RADDR-1:0] rs_q;
  logic [RADDR-1:0] rt_q;
  logic [RADDR-1:0] wn_q;
  logic [XLEN-1:0]  qa_q;
  logic [XLEN-1:0]  qb_q;
  logic [XLEN-1:0]  imm_q;

  logic             busy;
  logic             valid_out;
  logic [XLEN-1:0]  fwd_a;
  logic [XLEN-1:0]  fwd_b;
  logic [XLEN-1:0]  alua;
  logic [XLEN-1:0]  alub;
  logic [SHW-1:0]   shamt;
  logic [XLEN-1:0]  alu_res;
  logic [XLEN-1:0]  result;

  // ID/EX register: flush kills, otherwise load unless the stage is stalled
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      valid_q  <= 1'b0;
      wreg_q   <= 1'b0;
      m2reg_q  <= 1'b0;
      wmem_q   <= 1'b0;
      aluc_q   <= '0;
      shift_q  <= 1'b0;
      aluimm_q <= 1'b0;
      rs_q     <= '0;
      rt_q     <= '0;
      wn_q     <= '0;
      qa_q     <= '0;
      qb_q     <= '0;
      imm_q    <= '0;
    end else if (bus.flush) begin
      valid_q  <= 1'b0;
    end else if (!busy) begin
      valid_q  <= bus.id_valid;
      wreg_q   <= bus.id_wreg;
      m2reg_q  <= bus.id_m2reg;
      wmem_q   <= bus.id_wmem;
      aluc_q   <= bus.id_aluc;
      shift_q  <= bus.id_shift;
      aluimm_q <= bus.id_aluimm;
      rs_q     <= bus.id_rs;
      rt_q     <= bus.id_rt;
      wn_q     <= bus.id_wn;
      qa_q     <= bus.id_qa;
      qb_q     <= bus.id_qb;
      imm_q    <= bus.id_imm;
    end
  end

  // Operand forwarding: MEM result beats WB result, register 0 is never bypassed
  // NOTE: every always_comb output is given a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    fwd_a = qa_q;
    fwd_b = qb_q;
    if (rs_q != '0 && bus.mem_wreg && bus.mem_wn == rs_q) begin
      fwd_a = bus.mem_res;
    end else if (rs_q != '0 && bus.wb_wreg && bus.wb_wn == rs_q) begin
      fwd_a = bus.wb_res;
    end
    if (rt_q != '0 && bus.mem_wreg && bus.mem_wn == rt_q) begin
      fwd_b = bus.mem_res;
    end else if (rt_q != '0 && bus.wb_wreg && bus.wb_wn == rt_q) begin
      fwd_b = bus.wb_res;
    end
  end

  assign alua  = shift_q  ? imm_q : fwd_a;
  assign alub  = aluimm_q ? imm_q : fwd_b;
  assign shamt = alua[SHW-1:0];

  // Single-cycle ALU; the multiply opcode yields 0 here and is handled below
  always_comb begin
    alu_res = '0;
    casez (aluc_q)
      4'b?000: alu_res = alua + alub;
      4'b?100: alu_res = alua - alub;
      4'b?001: alu_res = alua & alub;
      4'b?101: alu_res = alua | alub;
      4'b?010: alu_res = alua ^ alub;
      4'b?110: alu_res = alub << (XLEN / 2);
      4'b0011: alu_res = alub << shamt;
      4'b0111: alu_res = alub >> shamt;
      4'b1111: alu_res = $signed(alub) >>> shamt;
      default: alu_res = '0;
    endcase
  end

`ifdef PIPE_EX_MUL_EN

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_RUN,
    MUL_DONE
  } mul_state_t;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);

  mul_state_t      state_q;
  mul_state_t      state_d;
  logic            is_mul;
  logic            mul_start;
  logic [XLEN-1:0] mcand_q;
  logic [XLEN-1:0] mplier_q;
  logic [XLEN-1:0] acc_q;
  logic [SHW-1:0]  cnt_q;

  assign is_mul    = valid_q && (aluc_q == OP_MUL);
  assign mul_start = (state_q == MUL_IDLE) && is_mul && !bus.flush;

  // Multiplier state register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= MUL_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Multiplier next state and stall/valid outputs; flush always returns to IDLE
  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    valid_out = valid_q;
    case (state_q)
      MUL_IDLE: begin
        if (is_mul) begin
          busy      = 1'b1;
          valid_out = 1'b0;
          state_d   = MUL_RUN;
        end
      end
      MUL_RUN: begin
        busy      = 1'b1;
        valid_out = 1'b0;
        if (cnt_q == CNT_LAST) begin
          state_d = MUL_DONE;
        end
      end
      MUL_DONE: begin
        state_d = MUL_IDLE;
      end
      default: begin
        state_d = MUL_IDLE;
      end
    endcase
    if (bus.flush) begin
      state_d = MUL_IDLE;
    end
  end

  // Shift-add datapath: capture operands once, then one multiplier bit per edge
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (mul_start) begin
      mcand_q  <= alua;
      mplier_q <= alub;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (state_q == MUL_RUN) begin
      acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
    end
  end

  assign result = (state_q == MUL_DONE) ? acc_q : alu_res;

`else

  assign busy      = 1'b0;
  assign valid_out = valid_q;
  assign result    = alu_res;

`endif

  assign bus.ex_busy       = busy;
  assign bus.ex_valid      = valid_out;
  assign bus.ex_wreg       = wreg_q  & valid_out;
  assign bus.ex_m2reg      = m2reg_q & valid_out;
  assign bus.ex_wmem       = wmem_q  & valid_out;
  assign bus.ex_wn         = wn_q;
  assign bus.ex_alu_result = result;
  assign bus.ex_di         = fwd_b;
  assign bus.ex_z          = (result == '0);

endmodule

// File: tb/tb_pipe_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_pipe_ex_stage
// Scoreboard bench: each issued instruction pushes its expected outcome, and
// the entry is popped and compared when the stage shows ex_valid.
// ---------------------------------------------------------------------------
module tb_pipe_ex_stage;

  localparam int XLEN  = 32;
  localparam int RADDR = 5;

  typedef struct {
    string           tag;
    logic [XLEN-1:0] res;
    logic [XLEN-1:0] di;
    logic [RADDR-1:0] wn;
    logic            wreg;
    logic            m2reg;
    logic            wmem;
  } exp_t;

  logic clk;
  logic clrn;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  pipe_ex_stage_if #(.XLEN(XLEN), .RADDR(RADDR)) bus ();

  pipe_ex_stage #(.XLEN(XLEN), .RADDR(RADDR)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_fwd(input logic mw, input logic [RADDR-1:0] mwn, input logic [XLEN-1:0] mres,
                         input logic ww, input logic [RADDR-1:0] wwn, input logic [XLEN-1:0] wres);
    bus.mem_wreg = mw;
    bus.mem_wn   = mwn;
    bus.mem_res  = mres;
    bus.wb_wreg  = ww;
    bus.wb_wn    = wwn;
    bus.wb_res   = wres;
  endtask

  task automatic present(input logic v, input logic [3:0] aluc, input logic sh, input logic ai,
                         input logic [RADDR-1:0] rs, input logic [RADDR-1:0] rt,
                         input logic [RADDR-1:0] wn, input logic [XLEN-1:0] qa,
                         input logic [XLEN-1:0] qb, input logic [XLEN-1:0] imm);
    bus.id_valid  = v;
    bus.id_wreg   = 1'b1;
    bus.id_m2reg  = wn[0];
    bus.id_wmem   = wn[1];
    bus.id_aluc   = aluc;
    bus.id_shift  = sh;
    bus.id_aluimm = ai;
    bus.id_rs     = rs;
    bus.id_rt     = rt;
    bus.id_wn     = wn;
    bus.id_qa     = qa;
    bus.id_qb     = qb;
    bus.id_imm    = imm;
  endtask

  task automatic push_exp(input string tag, input logic [RADDR-1:0] wn,
                          input logic [XLEN-1:0] res, input logic [XLEN-1:0] di);
    exp_t e;
    e.tag   = tag;
    e.res   = res;
    e.di    = di;
    e.wn    = wn;
    e.wreg  = 1'b1;
    e.m2reg = wn[0];
    e.wmem  = wn[1];
    sb.push_back(e);
  endtask

  // Wait (bounded) for ex_valid at the current sample point, then score it
  task automatic collect(input int bound);
    bit got = 1'b0;
    for (int i = 0; i <= bound && !got; i++) begin
      if (bus.ex_valid === 1'b1) begin
        got = 1'b1;
        if (sb.size() == 0) begin
          check("sb_empty", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.tag, "_res"},   64'(bus.ex_alu_result), 64'(e.res));
          check({e.tag, "_di"},    64'(bus.ex_di),         64'(e.di));
          check({e.tag, "_wn"},    64'(bus.ex_wn),         64'(e.wn));
          check({e.tag, "_z"},     64'(bus.ex_z),          64'(e.res == '0));
          check({e.tag, "_ctl"},   64'({bus.ex_wreg, bus.ex_m2reg, bus.ex_wmem}),
                                   64'({e.wreg, e.m2reg, e.wmem}));
        end
      end else if (i < bound) begin
        @(posedge clk);
        #1;
      end
    end
    if (!got) check("timeout", 64'd0, 64'd1);
  endtask

  // Drive one instruction, let it load, then score it
  task automatic issue(input string tag, input logic [3:0] aluc, input logic sh, input logic ai,
                       input logic [RADDR-1:0] rs, input logic [RADDR-1:0] rt,
                       input logic [RADDR-1:0] wn, input logic [XLEN-1:0] qa,
                       input logic [XLEN-1:0] qb, input logic [XLEN-1:0] imm,
                       input logic [XLEN-1:0] exp_res, input logic [XLEN-1:0] exp_di);
    @(negedge clk);
    present(1'b1, aluc, sh, ai, rs, rt, wn, qa, qb, imm);
    push_exp(tag, wn, exp_res, exp_di);
    @(posedge clk);
    #1;
    bus.id_valid = 1'b0;
    collect(3);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 64'(bus.ex_valid), 64'd0);
    check({tag, "_busy"},  64'(bus.ex_busy),  64'd0);
    check({tag, "_ctl"},   64'({bus.ex_wreg, bus.ex_m2reg, bus.ex_wmem}), 64'd0);
  endtask

  function automatic logic [XLEN-1:0] ref_alu(input logic [3:0] op, input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    case (op)
      4'b0000: return a + b;
      4'b0100: return a - b;
      4'b0001: return a & b;
      4'b0101: return a | b;
      4'b0010: return a ^ b;
      4'b0011: return b << a[4:0];
      4'b0111: return b >> a[4:0];
      4'b1111: return XLEN'($signed(b) >>> a[4:0]);
      default: return '0;
    endcase
  endfunction

  initial begin
    logic [3:0]      ops [8];
    logic [XLEN-1:0] mul_exp;
    int              mul_busy_exp;
    int              busy_cnt;

    ops = '{4'b0000, 4'b0100, 4'b0001, 4'b0101, 4'b0010, 4'b0011, 4'b0111, 4'b1111};
`ifdef PIPE_EX_MUL_EN
    mul_exp      = 32'hFFFF_FFFD;
    mul_busy_exp = XLEN + 1;
`else
    mul_exp      = '0;
    mul_busy_exp = 0;
`endif

    clrn      = 1'b0;
    bus.flush = 1'b0;
    present(1'b0, 4'b0000, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0);
    set_fwd(1'b0, '0, '0, 1'b0, '0, '0);

    // Reset state
    #2;
    check_idle_outputs("rst0");
    check("rst0_wn",  64'(bus.ex_wn),         64'd0);
    check("rst0_res", 64'(bus.ex_alu_result), 64'd0);
    check("rst0_z",   64'(bus.ex_z),          64'd1);
    check("rst0_di",  64'(bus.ex_di),         64'd0);
    repeat (2) @(negedge clk);
    clrn = 1'b1;

    // Add with MEM forwarding on rs and WB forwarding on rt
    set_fwd(1'b1, 5'd3, 32'd100, 1'b1, 5'd4, 32'd20);
    issue("fwd_add", 4'b0000, 1'b0, 1'b0, 5'd3, 5'd4, 5'd7, 32'd5, 32'd7, '0, 32'd120, 32'd20);

    // Asynchronous reset in the middle of a cycle with live state
    #2;
    clrn = 1'b0;
    #1;
    check_idle_outputs("rst1");
    check("rst1_wn",  64'(bus.ex_wn),         64'd0);
    check("rst1_res", 64'(bus.ex_alu_result), 64'd0);
    check("rst1_z",   64'(bus.ex_z),          64'd1);
    check("rst1_di",  64'(bus.ex_di),         64'd0);
    @(negedge clk);
    clrn = 1'b1;

    // MEM beats WB on the same register
    set_fwd(1'b1, 5'd2, 32'd9, 1'b1, 5'd2, 32'd8);
    issue("prio", 4'b0000, 1'b0, 1'b0, 5'd2, 5'd5, 5'd6, 32'd1, 32'd10, '0, 32'd19, 32'd10);

    // Register 0 is never forwarded
    set_fwd(1'b1, 5'd0, 32'd77, 1'b1, 5'd0, 32'd66);
    issue("r0", 4'b0000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5, 32'd33, 32'd2, '0, 32'd35, 32'd2);
    set_fwd(1'b0, '0, '0, 1'b0, '0, '0);

    // Shifts, lui and a wrapping subtract
    issue("sra", 4'b1111, 1'b1, 1'b0, 5'd1, 5'd6, 5'd8, 32'd0, 32'h8000_0000, 32'd4,
          32'hF800_0000, 32'h8000_0000);
    issue("lui", 4'b0110, 1'b0, 1'b1, 5'd1, 5'd6, 5'd9, 32'd0, 32'hDEAD_BEEF, 32'h1234,
          32'h1234_0000, 32'hDEAD_BEEF);
    issue("sub_wrap", 4'b0100, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd10, 32'd15, '0,
          32'hFFFF_FFFB, 32'd15);
    issue("sub_zero", 4'b1100, 1'b0, 1'b0, 5'd1, 5'd2, 5'd2, 32'd42, 32'd42, '0, 32'd0, 32'd42);

    // Random register-register operations against the reference model
    for (int i = 0; i < 8; i++) begin
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      a = $urandom;
      b = $urandom;
      issue($sformatf("rnd%0d", i), ops[i], 1'b0, 1'b0, 5'd10, 5'd11, 5'(12 + i), a, b, '0,
            ref_alu(ops[i], a, b), b);
    end

    // Flush beats load; an invalid instruction gates its control bits
    @(negedge clk);
    present(1'b1, 4'b0000, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd1, 32'd1, '0);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.id_valid = 1'b0;
    check_idle_outputs("flush_load");
    @(negedge clk);
    present(1'b0, 4'b0000, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd1, 32'd1, '0);
    @(posedge clk);
    #1;
    check_idle_outputs("id_invalid");

    // Multiply with operands captured once; next instruction waits on id_*
    @(negedge clk);
    set_fwd(1'b1, 5'd3, 32'hFFFF_FFFF, 1'b0, '0, '0);
    present(1'b1, 4'b1011, 1'b0, 1'b0, 5'd3, 5'd4, 5'd9, 32'd0, 32'd3, '0);
    push_exp("mul", 5'd9, mul_exp, 32'd3);
    @(posedge clk);
    #1;
    present(1'b1, 4'b0000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd10, 32'd1, 32'd2, '0);
    busy_cnt = 0;
    for (int i = 0; i < 60 && bus.ex_busy === 1'b1; i++) begin
      busy_cnt++;
      if (busy_cnt == 1) check("mul_valid_low", 64'(bus.ex_valid), 64'd0);
      if (busy_cnt == 5) bus.mem_res = 32'h1234_5678;
      @(posedge clk);
      #1;
    end
    check("mul_busy_cycles", 64'(busy_cnt), 64'(mul_busy_exp));
    collect(0);
    push_exp("after_mul", 5'd10, 32'd3, 32'd2);
    @(posedge clk);
    #1;
    bus.id_valid = 1'b0;
    collect(0);
    set_fwd(1'b0, '0, '0, 1'b0, '0, '0);

    // Flush during the tenth RUN cycle of a multiply
    @(negedge clk);
    present(1'b1, 4'b1011, 1'b0, 1'b0, 5'd1, 5'd2, 5'd11, 32'd7, 32'd6, '0);
    @(posedge clk);
    #1;
    bus.id_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check_idle_outputs("mul_flush");
    issue("post_flush", 4'b0101, 1'b0, 1'b0, 5'd1, 5'd2, 5'd12, 32'h0F0, 32'h00F, '0,
          32'h0FF, 32'h00F);

    // Reset during a multiply leaves nothing behind
    @(negedge clk);
    present(1'b1, 4'b1011, 1'b0, 1'b0, 5'd1, 5'd2, 5'd13, 32'd9, 32'd9, '0);
    @(posedge clk);
    #1;
    bus.id_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    clrn = 1'b0;
    #1;
    check_idle_outputs("mul_rst");
    check("mul_rst_res", 64'(bus.ex_alu_result), 64'd0);
    @(negedge clk);
    clrn = 1'b1;
    issue("post_rst", 4'b0010, 1'b0, 1'b0, 5'd1, 5'd2, 5'd14, 32'hFF00, 32'h0FF0, '0,
          32'hF0F0, 32'h0FF0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
